// File: rtl/timer0_pkg.sv
// Timer0 shared definitions: default I/O addresses, register bit positions,
// clock-select and compare-output encodings, and the compare-output action.
package timer0_pkg;

  // Default I/O-space addresses of the registers owned by Timer0
  localparam logic [5:0] TCNT_ADDR_DEF  = 6'h32;
  localparam logic [5:0] TCCR_ADDR_DEF  = 6'h33;
  localparam logic [5:0] OCR_ADDR_DEF   = 6'h3C;
  localparam logic [5:0] TIMSK_ADDR_DEF = 6'h39;
  localparam logic [5:0] TIFR_ADDR_DEF  = 6'h38;

  // TCCR0 bit positions
  localparam int TCCR_FOC0   = 7;
  localparam int TCCR_WGM00  = 6;
  localparam int TCCR_COM_HI = 5;
  localparam int TCCR_COM_LO = 4;
  localparam int TCCR_WGM01  = 3;
  localparam int TCCR_CS_HI  = 2;
  localparam int TCCR_CS_LO  = 0;

  // TIMSK / TIFR bit positions (only the Timer0 bits are implemented)
  localparam int TIMSK_TOIE0 = 0;
  localparam int TIMSK_OCIE0 = 1;
  localparam int TIFR_TOV0   = 0;
  localparam int TIFR_OCF0   = 1;

  // Clock-select encoding
  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_DIV1     = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs_e;

  // Compare-output mode encoding
  typedef enum logic [1:0] {
    COM_NONE   = 2'd0,
    COM_TOGGLE = 2'd1,
    COM_CLEAR  = 2'd2,
    COM_SET    = 2'd3
  } com_e;

  // Value of the OC0 pin after applying a compare-output action to it
  function automatic logic com_apply(input com_e com, input logic pin);
    logic res;
    res = pin;
    case (com)
      COM_NONE:   res = pin;
      COM_TOGGLE: res = ~pin;
      COM_CLEAR:  res = 1'b0;
      COM_SET:    res = 1'b1;
      default:    res = pin;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/timer0_prescaler.sv
// Timer0 tick source: 10-bit free-running prescaler, t0_pin synchronizer
// with edge detect, and the clock-select mux producing a one-cycle tick.
module timer0_prescaler
  import timer0_pkg::*;
(
  input  logic sysClock,
  input  logic nReset,
  input  cs_e  i_cs,
  input  logic i_t0_pin,
  output logic o_tick
);

  logic [9:0] r_presc;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_edge_prev;
  logic       w_rise;
  logic       w_fall;

  // Prescaler advances whenever the timer is clocked by anything; it is
  // never cleared by a clock-select change, only by reset.
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      r_presc <= '0;
    end else if (i_cs != CS_STOP) begin
      r_presc <= r_presc + 10'd1;
    end
  end

  // Two-flop synchronizer for the asynchronous pin plus one history flop
  // for edge detection; a pin edge becomes a tick on the third clock edge.
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_edge_prev <= 1'b0;
    end else begin
      r_sync1     <= i_t0_pin;
      r_sync2     <= r_sync1;
      r_edge_prev <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_edge_prev;
  assign w_fall = ~r_sync2 & r_edge_prev;

  // Clock-select mux: a /N tick fires in the cycle where the low log2(N)
  // prescaler bits are all ones, so it lasts exactly one cycle.
  always_comb begin
    o_tick = 1'b0;
    case (i_cs)
      CS_STOP:     o_tick = 1'b0;
      CS_DIV1:     o_tick = 1'b1;
      CS_DIV8:     o_tick = &r_presc[2:0];
      CS_DIV64:    o_tick = &r_presc[5:0];
      CS_DIV256:   o_tick = &r_presc[7:0];
      CS_DIV1024:  o_tick = &r_presc[9:0];
      CS_EXT_FALL: o_tick = w_fall;
      CS_EXT_RISE: o_tick = w_rise;
      default:     o_tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/timer0_controller.sv
// Timer0 controller: TCNT0/TCCR0/OCR0 and Timer0 TIMSK/TIFR bits on the CPU
// I/O bus, normal and CTC counting, overflow/compare flags and OC0 output.
module timer0_controller
  import timer0_pkg::*;
#(
  parameter logic [5:0] TCNT_ADDR  = TCNT_ADDR_DEF,
  parameter logic [5:0] TCCR_ADDR  = TCCR_ADDR_DEF,
  parameter logic [5:0] OCR_ADDR   = OCR_ADDR_DEF,
  parameter logic [5:0] TIMSK_ADDR = TIMSK_ADDR_DEF,
  parameter logic [5:0] TIFR_ADDR  = TIFR_ADDR_DEF
) (
  input  logic       sysClock,
  input  logic       nReset,
  input  logic [5:0] io_addr,
  input  logic       io_we,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       io_hit,
  input  logic       t0_pin,
  output logic       irq_ovf,
  output logic       irq_comp,
  input  logic       ack_ovf,
  input  logic       ack_comp,
  output logic       oc0,
  output logic [7:0] tcnt,
  output logic [7:0] tccr
);

  // Architectural state; FOC0 is a strobe and has no storage
  logic [7:0] r_tcnt;
  logic [6:0] r_tccr;
  logic [7:0] r_ocr;
  logic       r_toie;
  logic       r_ocie;
  logic       r_tov;
  logic       r_ocf;
  logic       r_oc0;
  logic       r_cmp_block;

  logic       w_wr_tcnt;
  logic       w_wr_tccr;
  logic       w_wr_ocr;
  logic       w_wr_timsk;
  logic       w_wr_tifr;
  logic       w_tick;
  logic       w_tick_cnt;
  logic       w_ctc;
  logic       w_eq;
  logic       w_match;
  logic       w_foc;
  logic       w_tov_set;
  logic       w_tov_clr;
  logic       w_ocf_clr;
  logic [7:0] w_tcnt_next;
  logic       w_oc0_next;
  cs_e        w_cs;
  com_e       w_com;
  com_e       w_com_wr;

  // Bus write decode
  assign w_wr_tcnt  = io_we && (io_addr == TCNT_ADDR);
  assign w_wr_tccr  = io_we && (io_addr == TCCR_ADDR);
  assign w_wr_ocr   = io_we && (io_addr == OCR_ADDR);
  assign w_wr_timsk = io_we && (io_addr == TIMSK_ADDR);
  assign w_wr_tifr  = io_we && (io_addr == TIFR_ADDR);

  // Configuration fields of the currently stored TCCR0; a simultaneous
  // TCCR0 write only affects ticks from the next cycle on.
  assign w_cs     = cs_e'(r_tccr[TCCR_CS_HI:TCCR_CS_LO]);
  assign w_com    = com_e'(r_tccr[TCCR_COM_HI:TCCR_COM_LO]);
  assign w_com_wr = com_e'(io_wdata[TCCR_COM_HI:TCCR_COM_LO]);
  assign w_ctc    = r_tccr[TCCR_WGM01] & ~r_tccr[TCCR_WGM00];

  timer0_prescaler u_prescaler (
    .sysClock (sysClock),
    .nReset   (nReset),
    .i_cs     (w_cs),
    .i_t0_pin (t0_pin),
    .o_tick   (w_tick)
  );

  // A CPU write to TCNT0 swallows a coincident tick; the first tick after
  // such a write is also barred from producing a compare match.
  assign w_tick_cnt = w_tick & ~w_wr_tcnt;
  assign w_eq       = (r_tcnt == r_ocr);
  assign w_match    = w_tick_cnt & w_eq & ~r_cmp_block;
  assign w_foc      = w_wr_tccr & io_wdata[TCCR_FOC0];
  assign w_tov_set  = w_tick_cnt & ~w_ctc & (r_tcnt == 8'hFF);
  assign w_tov_clr  = (w_wr_tifr & io_wdata[TIFR_TOV0]) | ack_ovf;
  assign w_ocf_clr  = (w_wr_tifr & io_wdata[TIFR_OCF0]) | ack_comp;

  // Next counter value: bus write, CTC wrap on equality, or plain increment
  always_comb begin
    w_tcnt_next = r_tcnt;
    if (w_wr_tcnt) begin
      w_tcnt_next = io_wdata;
    end else if (w_tick_cnt) begin
      if (w_ctc && w_eq) begin
        w_tcnt_next = 8'h00;
      end else begin
        w_tcnt_next = r_tcnt + 8'd1;
      end
    end
  end

  // Next OC0 level: a real match uses the stored COM bits, a forced compare
  // uses the COM bits being written alongside FOC0.
  always_comb begin
    w_oc0_next = r_oc0;
    if (w_match) begin
      w_oc0_next = com_apply(w_com, w_oc0_next);
    end
    if (w_foc) begin
      w_oc0_next = com_apply(w_com_wr, w_oc0_next);
    end
  end

  // Counter and compare-block state
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      r_tcnt      <= 8'h00;
      r_cmp_block <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_next;
      if (w_wr_tcnt) begin
        r_cmp_block <= 1'b1;
      end else if (w_tick_cnt) begin
        r_cmp_block <= 1'b0;
      end
    end
  end

  // Configuration registers written from the bus
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      r_tccr <= 7'h00;
      r_ocr  <= 8'h00;
      r_toie <= 1'b0;
      r_ocie <= 1'b0;
    end else begin
      if (w_wr_tccr) begin
        r_tccr <= io_wdata[6:0];
      end
      if (w_wr_ocr) begin
        r_ocr <= io_wdata;
      end
      if (w_wr_timsk) begin
        r_toie <= io_wdata[TIMSK_TOIE0];
        r_ocie <= io_wdata[TIMSK_OCIE0];
      end
    end
  end

  // Interrupt flags: a set in the same cycle as a clear keeps the flag set
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      r_tov <= 1'b0;
      r_ocf <= 1'b0;
    end else begin
      if (w_tov_set) begin
        r_tov <= 1'b1;
      end else if (w_tov_clr) begin
        r_tov <= 1'b0;
      end
      if (w_match) begin
        r_ocf <= 1'b1;
      end else if (w_ocf_clr) begin
        r_ocf <= 1'b0;
      end
    end
  end

  // Compare output pin
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      r_oc0 <= 1'b0;
    end else begin
      r_oc0 <= w_oc0_next;
    end
  end

  // Combinational read-back of the addressed register
  always_comb begin
    io_rdata = 8'h00;
    io_hit   = 1'b1;
    case (io_addr)
      TCNT_ADDR:  io_rdata = r_tcnt;
      TCCR_ADDR:  io_rdata = {1'b0, r_tccr};
      OCR_ADDR:   io_rdata = r_ocr;
      TIMSK_ADDR: io_rdata = {6'b0, r_ocie, r_toie};
      TIFR_ADDR:  io_rdata = {6'b0, r_ocf, r_tov};
      default: begin
        io_rdata = 8'h00;
        io_hit   = 1'b0;
      end
    endcase
  end

  assign irq_ovf  = r_tov & r_toie;
  assign irq_comp = r_ocf & r_ocie;
  assign oc0      = r_oc0;
  assign tcnt     = r_tcnt;
  assign tccr     = {1'b0, r_tccr};

endmodule

// File: tb/tb_timer0_controller.sv
// Scoreboard bench for timer0_controller: directed scenarios plus random
// bus/pin traffic, checked every cycle against a behavioural model.
module tb_timer0_controller;

  localparam logic [5:0] A_TCNT  = 6'h32;
  localparam logic [5:0] A_TCCR  = 6'h33;
  localparam logic [5:0] A_OCR   = 6'h3C;
  localparam logic [5:0] A_TIMSK = 6'h39;
  localparam logic [5:0] A_TIFR  = 6'h38;

  typedef struct {
    logic       rst_n;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       ack_ovf;
    logic       ack_comp;
    logic       pin;
  } stim_t;

  typedef struct {
    logic [7:0] tcnt;
    logic [7:0] tccr;
    logic [7:0] rdata;
    logic       hit;
    logic       irq_ovf;
    logic       irq_comp;
    logic       oc0;
  } exp_t;

  logic       sysClock;
  logic       nReset;
  logic [5:0] io_addr;
  logic       io_we;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_hit;
  logic       t0_pin;
  logic       irq_ovf;
  logic       irq_comp;
  logic       ack_ovf;
  logic       ack_comp;
  logic       oc0;
  logic [7:0] tcnt;
  logic [7:0] tccr;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic pin_lvl = 1'b0;

  // Reference model state
  int   m_cnt, m_tccr, m_ocr, m_presc;
  bit   m_toie, m_ocie, m_tov, m_ocf, m_oc0, m_block;
  bit   m_pin [3];

  timer0_controller dut (
    .sysClock (sysClock),
    .nReset   (nReset),
    .io_addr  (io_addr),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_hit   (io_hit),
    .t0_pin   (t0_pin),
    .irq_ovf  (irq_ovf),
    .irq_comp (irq_comp),
    .ack_ovf  (ack_ovf),
    .ack_comp (ack_comp),
    .oc0      (oc0),
    .tcnt     (tcnt),
    .tccr     (tccr)
  );

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int divisor(input int cs);
    case (cs)
      1: return 1;
      2: return 8;
      3: return 64;
      4: return 256;
      5: return 1024;
      default: return 0;
    endcase
  endfunction

  function automatic bit com_act(input int com, input bit pin);
    case (com)
      1: return !pin;
      2: return 1'b0;
      3: return 1'b1;
      default: return pin;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tccr = 0; m_ocr = 0; m_presc = 0;
    m_toie = 0; m_ocie = 0; m_tov = 0; m_ocf = 0; m_oc0 = 0; m_block = 0;
    m_pin[0] = 0; m_pin[1] = 0; m_pin[2] = 0;
  endtask

  task automatic model_step(input stim_t s);
    int  cs, com, n;
    bit  tick, ctc, wr_cnt, counted, match, tov_set;
    if (!s.rst_n) begin
      model_reset();
      return;
    end
    cs  = m_tccr % 8;
    com = (m_tccr / 16) % 4;
    ctc = ((m_tccr / 8) % 2 == 1) && ((m_tccr / 64) % 2 == 0);
    tick = 0;
    n = divisor(cs);
    if (n != 0) tick = ((m_presc + 1) % n) == 0;
    // pin seen through two sync flops and an edge flop: sampled 2 vs 3 edges ago
    if (cs == 6) tick = m_pin[2] && !m_pin[1];
    if (cs == 7) tick = !m_pin[2] && m_pin[1];
    if (cs != 0) m_presc = (m_presc + 1) % 1024;
    m_pin[2] = m_pin[1]; m_pin[1] = m_pin[0]; m_pin[0] = s.pin;

    wr_cnt  = s.we && s.addr == A_TCNT;
    counted = tick && !wr_cnt;
    match   = counted && m_cnt == m_ocr && !m_block;
    tov_set = counted && !ctc && m_cnt == 255;

    if (match) begin
      m_oc0 = com_act(com, m_oc0);
    end
    if (s.we && s.addr == A_TCCR && s.wdata[7]) m_oc0 = com_act(int'(s.wdata[5:4]), m_oc0);

    if (tov_set) m_tov = 1;
    else if ((s.we && s.addr == A_TIFR && s.wdata[0]) || s.ack_ovf) m_tov = 0;
    if (match) m_ocf = 1;
    else if ((s.we && s.addr == A_TIFR && s.wdata[1]) || s.ack_comp) m_ocf = 0;

    if (wr_cnt) begin
      m_cnt = s.wdata;
      m_block = 1;
    end else if (counted) begin
      m_block = 0;
      if (ctc && m_cnt == m_ocr) m_cnt = 0;
      else m_cnt = (m_cnt + 1) % 256;
    end
    if (s.we && s.addr == A_TCCR)  m_tccr = s.wdata % 128;
    if (s.we && s.addr == A_OCR)   m_ocr  = s.wdata;
    if (s.we && s.addr == A_TIMSK) begin
      m_toie = s.wdata[0];
      m_ocie = s.wdata[1];
    end
  endtask

  function automatic exp_t model_out(input logic [5:0] addr);
    exp_t e;
    e.tcnt = 8'(m_cnt);
    e.tccr = 8'(m_tccr);
    e.irq_ovf  = m_tov && m_toie;
    e.irq_comp = m_ocf && m_ocie;
    e.oc0 = m_oc0;
    e.hit = 1'b1;
    case (addr)
      A_TCNT:  e.rdata = 8'(m_cnt);
      A_TCCR:  e.rdata = 8'(m_tccr);
      A_OCR:   e.rdata = 8'(m_ocr);
      A_TIMSK: e.rdata = {6'b0, m_ocie, m_toie};
      A_TIFR:  e.rdata = {6'b0, m_ocf, m_tov};
      default: begin
        e.rdata = 8'h00;
        e.hit = 1'b0;
      end
    endcase
    return e;
  endfunction

  // ---------------- stimulus ----------------
  function automatic stim_t st(input logic we, input logic [5:0] addr, input logic [7:0] wd);
    stim_t s;
    s.rst_n = 1'b1; s.we = we; s.addr = addr; s.wdata = wd;
    s.ack_ovf = 1'b0; s.ack_comp = 1'b0; s.pin = pin_lvl;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    @(negedge sysClock);
    nReset   = s.rst_n;
    io_we    = s.we;
    io_addr  = s.addr;
    io_wdata = s.wdata;
    ack_ovf  = s.ack_ovf;
    ack_comp = s.ack_comp;
    t0_pin   = s.pin;
    model_step(s);
    exp_q.push_back(model_out(s.addr));
  endtask

  task automatic wr(input logic [5:0] addr, input logic [7:0] wd);
    drive(st(1'b1, addr, wd));
  endtask

  task automatic idle(input int n, input logic [5:0] addr);
    for (int i = 0; i < n; i++) drive(st(1'b0, addr, 8'h00));
  endtask

  task automatic peek();
    @(posedge sysClock);
    #2;
  endtask

  task automatic do_reset();
    stim_t s;
    s = st(1'b0, 6'h00, 8'h00);
    s.rst_n = 1'b0;
    drive(s);
    drive(s);
    s.rst_n = 1'b1;
    drive(s);
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(posedge sysClock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_tcnt",  tcnt,     mon_e.tcnt);
      chk("sb_tccr",  tccr,     mon_e.tccr);
      chk("sb_rdata", io_rdata, mon_e.rdata);
      chk("sb_hit",   io_hit,   mon_e.hit);
      chk("sb_irqovf", irq_ovf, mon_e.irq_ovf);
      chk("sb_irqcmp", irq_comp, mon_e.irq_comp);
      chk("sb_oc0",   oc0,      mon_e.oc0);
    end
  end

  initial begin
    stim_t s;
    int    k;
    logic [5:0] addrs [7];
    addrs[0] = A_TCNT; addrs[1] = A_TCCR; addrs[2] = A_OCR; addrs[3] = A_TIMSK;
    addrs[4] = A_TIFR; addrs[5] = 6'h00;  addrs[6] = 6'h3F;
    nReset = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
    ack_ovf = 1'b0; ack_comp = 1'b0; t0_pin = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    peek();
    chk("reset_tcnt", tcnt, 8'h00);
    chk("reset_oc0", oc0, 1'b0);

    // Overflow, interrupt and acknowledge
    wr(A_TCNT, 8'hFE);
    wr(A_TIMSK, 8'h01);
    wr(A_TCCR, 8'h01);
    idle(2, A_TIFR);
    peek();
    chk("ovf_tcnt", tcnt, 8'h00);
    chk("ovf_irq", irq_ovf, 1'b1);
    s = st(1'b0, A_TIFR, 8'h00);
    s.ack_ovf = 1'b1;
    drive(s);
    peek();
    chk("ovf_ack", irq_ovf, 1'b0);

    // /8 prescaler from reset
    do_reset();
    wr(A_TCCR, 8'h02);
    idle(40, A_TCNT);
    peek();
    chk("div8_tcnt", tcnt, 8'd5);

    // CTC wrap with toggle
    do_reset();
    wr(A_OCR, 8'h03);
    wr(A_TIMSK, 8'h02);
    wr(A_TCCR, 8'h19);
    idle(4, A_TCNT);
    peek();
    chk("ctc_tcnt_a", tcnt, 8'h00);
    chk("ctc_oc0_a", oc0, 1'b1);
    chk("ctc_irq", irq_comp, 1'b1);
    idle(4, A_TCNT);
    peek();
    chk("ctc_oc0_b", oc0, 1'b0);

    // Compare blocking after TCNT0 write; set beats TIFR clear
    do_reset();
    wr(A_OCR, 8'h10);
    wr(A_TIMSK, 8'h02);
    wr(A_TCCR, 8'h01);
    wr(A_TCNT, 8'h10);
    idle(1, A_TIFR);
    peek();
    chk("blk_tifr", io_rdata, 8'h00);
    chk("blk_tcnt", tcnt, 8'h11);
    wr(A_TCNT, 8'h0E);
    idle(2, A_TIFR);
    wr(A_TIFR, 8'h02);
    peek();
    chk("setwins_tifr", io_rdata, 8'h02);
    wr(A_TIFR, 8'h02);
    peek();
    chk("tifr_clear", io_rdata, 8'h00);

    // External rising-edge clock
    do_reset();
    pin_lvl = 1'b0;
    wr(A_TCCR, 8'h07);
    idle(3, A_TCNT);
    pin_lvl = 1'b1;
    idle(1, A_TCNT);
    idle(1, A_TCNT);
    peek();
    chk("ext_lat_a", tcnt, 8'd0);
    idle(1, A_TCNT);
    peek();
    chk("ext_lat_b", tcnt, 8'd1);
    pin_lvl = 1'b0;
    idle(6, A_TCNT);
    peek();
    chk("ext_fall", tcnt, 8'd1);
    pin_lvl = 1'b1;
    idle(1, A_TCNT);
    pin_lvl = 1'b0;
    idle(5, A_TCNT);
    peek();
    chk("ext_pulse", tcnt, 8'd2);
    for (int i = 0; i < 4; i++) begin
      pin_lvl = ~pin_lvl;
      idle(1, A_TCNT);
    end
    pin_lvl = 1'b0;
    idle(4, A_TCNT);
    peek();
    chk("ext_fast", tcnt, 8'd4);

    // Mid-count asynchronous reset
    do_reset();
    wr(A_TIMSK, 8'h03);
    wr(A_OCR, 8'hFE);
    wr(A_TCCR, 8'h31);
    wr(A_TCNT, 8'hFD);
    idle(3, A_TCNT);
    peek();
    chk("pre_rst_irqs", {irq_ovf, irq_comp, oc0}, 3'b111);
    #1;
    nReset = 1'b0;
    model_reset();
    #1;
    chk("arst_tcnt", tcnt, 8'h00);
    chk("arst_tccr", tccr, 8'h00);
    chk("arst_oc0", oc0, 1'b0);
    chk("arst_irqs", {irq_ovf, irq_comp}, 2'b00);
    s = st(1'b0, A_TCNT, 8'h00);
    s.rst_n = 1'b0;
    drive(s);
    idle(5, A_TCNT);
    peek();
    chk("arst_hold", tcnt, 8'h00);
    wr(A_TCCR, 8'h01);
    idle(3, A_TCNT);
    peek();
    chk("arst_resume", tcnt, 8'd3);

    // Random traffic
    do_reset();
    wr(A_TCCR, 8'h01);
    for (int i = 0; i < 800; i++) begin
      k = int'($urandom_range(0, 6));
      s = st(($urandom % 4) == 0, addrs[k], 8'($urandom));
      if (s.we && s.addr == A_TCCR && ($urandom % 2) == 0) s.wdata[2:0] = 3'd1;
      s.ack_ovf  = ($urandom % 8) == 0;
      s.ack_comp = ($urandom % 8) == 0;
      if (($urandom % 3) == 0) pin_lvl = ~pin_lvl;
      s.pin = pin_lvl;
      drive(s);
    end

    idle(2, A_TIFR);
    repeat (3) @(posedge sysClock);
    #2;
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
